// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART receiver and its user: baud tick, serial line, word and status.
// UART_RX_PARITY_EN adds the parity_err status line.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, busy, parity_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, busy, parity_err
  );
`else
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, busy
  );
`endif
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receive engine: start/data/stop recovery with a one-cycle done pulse.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the parity_err status.
module uart_receiver #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     PCLK,
  input  logic     PRESETn,
  uart_rx_if.slave bus
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            ferr_reg, ferr_next;
  logic            done_reg, done_next;
  logic            rx_meta_reg, rx_s_reg;
  // A start is only accepted once the line has been seen high; blocks re-triggering on a held break.
  logic            seen_high_reg, seen_high_next;
`ifdef UART_RX_PARITY_EN
  logic            parity_bit_reg, parity_bit_next;
  logic            perr_reg, perr_next;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg      <= IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      shift_reg      <= '0;
      dout_reg       <= '0;
      ferr_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rx_meta_reg    <= 1'b1;
      rx_s_reg       <= 1'b1;
      seen_high_reg  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      perr_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      s_reg          <= s_next;
      n_reg          <= n_next;
      shift_reg      <= shift_next;
      dout_reg       <= dout_next;
      ferr_reg       <= ferr_next;
      done_reg       <= done_next;
      rx_meta_reg    <= bus.rx;
      rx_s_reg       <= rx_meta_reg;
      seen_high_reg  <= seen_high_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      perr_reg       <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    s_next          = s_reg;
    n_next          = n_reg;
    shift_next      = shift_reg;
    dout_next       = dout_reg;
    ferr_next       = ferr_reg;
    done_next       = 1'b0;
    seen_high_next  = rx_s_reg | seen_high_reg;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    perr_next       = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg && seen_high_reg) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_reg == 5'd7) begin
            if (!rx_s_reg) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_reg == 5'd15) begin
            shift_next = {rx_s_reg, shift_reg[DBIT-1:1]};
            s_next     = '0;
            n_next     = n_reg + 3'd1;
            if (n_reg == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_reg == 5'd15) begin
            parity_bit_next = rx_s_reg;
            s_next          = '0;
            state_next      = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_reg == 5'(SB_TICK - 1)) begin
            dout_next      = shift_reg;
            ferr_next      = ~rx_s_reg;
            done_next      = 1'b1;
            state_next     = IDLE;
            seen_high_next = rx_s_reg;
`ifdef UART_RX_PARITY_EN
            perr_next      = ^shift_reg ^ parity_bit_reg ^ PARITY_ODD;
`endif
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = done_reg;
  assign bus.frame_err    = ferr_reg;
  assign bus.busy         = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_reg;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 64 PCLK per bit, a negedge monitor captures every done pulse.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;
  localparam int DBIT     = 8;
  localparam int BIT_CLKS = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_receiver #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  logic [DBIT-1:0] cap_dout[$];
  logic            cap_ferr[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // s_tick: one cycle in four, changed on the falling edge
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  // Pulse monitor: capture word/status on the pulse, then check busy and pulse width one cycle later
  initial begin
    logic pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        check_val("busy_after_pulse", 32'(bus.busy), 32'd0);
        check_val("pulse_width", 32'(bus.rx_done_tick), 32'd0);
        pending = 1'b0;
      end else if (bus.rx_done_tick) begin
        pulse_cnt++;
        cap_dout.push_back(bus.dout);
        cap_ferr.push_back(bus.frame_err);
        pending = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < DBIT; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`endif
    drive_bit(stop_v);
  endtask

  task automatic expect_pulses(input string tag, input int target);
    int waited;
    waited = 0;
    while (pulse_cnt < target && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_val(tag, 32'(pulse_cnt), 32'(target));
  endtask

  task automatic check_frame(input string tag, input logic [DBIT-1:0] d, input logic fe);
    if (cap_dout.size() == 0) begin
      check_val({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_dout"}, 32'(cap_dout.pop_front()), 32'(d));
      check_val({tag, "_ferr"}, 32'(cap_ferr.pop_front()), 32'(fe));
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_dout", 32'(bus.dout), 32'd0);
    check_val("rst_ferr", 32'(bus.frame_err), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.rx_done_tick), 32'd0);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Single clean frame
    send_frame(8'hA5, 1'b1);
    expect_pulses("a5_pulses", 1);
    check_frame("a5", 8'hA5, 1'b0);
    drive_bit(1'b1);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    expect_pulses("b2b_pulses", 3);
    check_frame("b2b_first", 8'h00, 1'b0);
    check_frame("b2b_second", 8'hFF, 1'b0);
    drive_bit(1'b1);

    // Start glitch of 5 ticks
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_val("glitch_pulses", 32'(pulse_cnt), 32'd3);
    check_val("glitch_busy", 32'(bus.busy), 32'd0);
    check_val("glitch_dout_held", 32'(bus.dout), 32'hFF);

    // Framing error, then a clean frame clears it
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1);
    expect_pulses("ferr_pulses", 4);
    check_frame("ferr", 8'h3C, 1'b1);
    check_val("ferr_held", 32'(bus.frame_err), 32'd1);
    send_frame(8'h11, 1'b1);
    expect_pulses("clean_pulses", 5);
    check_frame("clean", 8'h11, 1'b0);
    drive_bit(1'b1);

    // Break: one frame with frame_err, no retrigger while held low
    bus.rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check_val("break_pulses", 32'(pulse_cnt), 32'd6);
    check_frame("break", 8'h00, 1'b1);
    check_val("break_idle", 32'(bus.busy), 32'd0);
    drive_bit(1'b1);
    send_frame(8'hC3, 1'b1);
    expect_pulses("post_break_pulses", 7);
    check_frame("post_break", 8'hC3, 1'b0);
    drive_bit(1'b1);

    // Reset mid-frame after 4 data bits of 0x5A
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h5A >> i) & 8'h01));
    rst_n = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_dout", 32'(bus.dout), 32'd0);
    check_val("midrst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check_val("midrst_no_pulse", 32'(pulse_cnt), 32'd7);
    send_frame(8'h77, 1'b1);
    expect_pulses("after_rst_pulses", 8);
    check_frame("after_rst", 8'h77, 1'b0);
    drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a correct parity bit is 1
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    expect_pulses("par_ok_pulses", 9);
    check_frame("par_ok", 8'h07, 1'b0);
    check_val("par_ok_perr", 32'(bus.parity_err), 32'd0);
    drive_bit(1'b1);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    expect_pulses("par_bad_pulses", 10);
    check_frame("par_bad", 8'h07, 1'b0);
    check_val("par_bad_perr", 32'(bus.parity_err), 32'd1);
    drive_bit(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
